dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter placed in front of the single-port data memory. It shares the memory between the CPU data port and the debug port. Each cycle it grants at most one access using round-robin priority. It drives the memory's write-enable, address and write data, and returns registered read data, a completion strobe and an error flag to the granted requester. A saturating stall counter reports how many cycles the CPU spent waiting on the debug port.

## Interface
Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the data memory; legal word index is 0..DEPTH_WORDS-1.
- STALL_W, 16, width of the CPU stall counter.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held with cpu_we/addr/wdata stable until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  32  byte address, must be word aligned.
- cpu_wdata  in  32  write data.
- cpu_gnt  out  1  combinational; access performed at this clock edge.
- cpu_rvalid  out  1  registered; one-cycle completion strobe, one cycle after cpu_gnt.
- cpu_rdata  out  32  registered read data; valid while cpu_rvalid=1.
- cpu_err  out  1  registered; qualifies cpu_rvalid; the access was misaligned or out of range.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err: identical to the cpu_* ports, for the debug port.
- cpu_stall_cnt  out  STALL_W  saturating count of cycles where cpu_req=1 and cpu_gnt=0.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  combinational memory read data for mem_addr.

## Operation
- State: last_gnt (0 = CPU, 1 = DBG), plus the registered response outputs and cpu_stall_cnt.
- Arbitration (combinational):
  - Only one request: grant it.
  - Both requesting: grant the port not equal to last_gnt.
  - Neither requesting: no grant.
  - last_gnt takes the granted port at the edge; it is unchanged when idle.
- Legality: an access is legal iff addr[1:0]==0 and addr[31:2] < DEPTH_WORDS.
- Memory drive:
  - mem_addr and mem_wdata follow the granted port; both are 0 when idle.
  - mem_we = granted port's we AND legal.
  - An illegal write is granted and completes with err=1, but never reaches the memory.
- Response (registered at the grant edge):
  - The granted port's rvalid goes to 1.
  - rdata = mem_rdata for a legal read, else 0. Writes return 0.
  - err = !legal.
  - The other port's rvalid and err go to 0.
  - rdata holds its value when rvalid=0.
- A port may re-request in the cycle its rvalid is high. Back-to-back accesses from a sole requester are granted every cycle.
- Stall counter increments when cpu_req & !cpu_gnt and saturates at 2^STALL_W-1. It never clears except by reset.
- Reset values:
  - last_gnt=1, so the CPU wins the first tie.
  - All rvalid, err and rdata = 0.
  - cpu_stall_cnt = 0.
  - Grants follow the requests combinationally even while rst_n=0, but mem_we is forced to 0 while rst_n=0.
- Reset mid-operation: any completion pending for the next edge is discarded, and rvalid stays 0.

## Timing
- Grant latency: 0 cycles. gnt is combinational on req and last_gnt.
- Write: the memory updates at the edge where gnt=1. rvalid follows one cycle later.
- Read: mem_rdata is sampled at the grant edge. rdata/rvalid are visible one cycle after gnt.
- Under continuous contention, each port is granted every other cycle, so the worst-case wait is 1 cycle.
- A write then read to the same address from different ports on consecutive grants returns the new data.

## Test plan
- Reset, then cpu_req write addr 0x10 data 0xDEADBEEF; next cycle cpu read 0x10 -> cpu_gnt same cycle on both, mem_we=1 only on the first, cpu_rdata=0xDEADBEEF with cpu_rvalid one cycle after the read grant, cpu_err=0.
- Both ports hold read requests for 6 cycles starting right after reset -> grants alternate CPU, DBG, CPU, DBG, CPU, DBG; cpu_stall_cnt=3 afterward.
- dbg write 0x20=0x12345678, then cpu read 0x20 on the next cycle while dbg idle -> cpu_rdata=0x12345678.
- cpu write to 0x102 (misaligned) and to 0x100 (word 64, out of range) -> granted, mem_we=0, cpu_rvalid=1 with cpu_err=1, cpu_rdata=0; memory contents unchanged on readback.
- Force cpu_stall_cnt near max (STALL_W=4, dbg_req held permanently high, cpu_req high) for 40 cycles -> the counter stops at 15.
- Assert rst_n=0 asynchronously mid-cycle during a granted read -> cpu_rvalid=0 immediately, no response after reset release, and the next tie goes to the CPU.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU data
// port and the debug port, with registered responses and a CPU stall counter.
module dmem_arbiter #(
    parameter int DEPTH_WORDS = 64,
    parameter int STALL_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_wdata,
    output logic               cpu_gnt,
    output logic               cpu_rvalid,
    output logic [31:0]        cpu_rdata,
    output logic               cpu_err,

    input  logic               dbg_req,
    input  logic               dbg_we,
    input  logic [31:0]        dbg_addr,
    input  logic [31:0]        dbg_wdata,
    output logic               dbg_gnt,
    output logic               dbg_rvalid,
    output logic [31:0]        dbg_rdata,
    output logic               dbg_err,

    output logic [STALL_W-1:0] cpu_stall_cnt,

    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    logic last_gnt;  // 0 = CPU granted last, 1 = debug granted last
    logic cpu_legal;
    logic dbg_legal;

    assign cpu_legal = (cpu_addr[1:0] == 2'b00) && (cpu_addr[31:2] < DEPTH_LIM);
    assign dbg_legal = (dbg_addr[1:0] == 2'b00) && (dbg_addr[31:2] < DEPTH_LIM);

    // On a tie the port that did not win last time goes first.
    assign cpu_gnt = cpu_req && (!dbg_req || last_gnt);
    assign dbg_gnt = dbg_req && (!cpu_req || !last_gnt);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we && cpu_legal;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we && dbg_legal;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
        // Grants still track requests in reset, but the memory must not be written.
        if (!rst_n) begin
            mem_we = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (cpu_gnt) begin
            last_gnt <= 1'b0;
        end else if (dbg_gnt) begin
            last_gnt <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rvalid <= 1'b0;
            cpu_err    <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rvalid <= 1'b0;
            dbg_err    <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            cpu_rvalid <= cpu_gnt;
            cpu_err    <= cpu_gnt && !cpu_legal;
            dbg_rvalid <= dbg_gnt;
            dbg_err    <= dbg_gnt && !dbg_legal;
            // rdata only moves on a grant so it holds while rvalid is low.
            if (cpu_gnt) begin
                cpu_rdata <= (!cpu_we && cpu_legal) ? mem_rdata : 32'h0;
            end
            if (dbg_gnt) begin
                dbg_rdata <= (!dbg_we && dbg_legal) ? mem_rdata : 32'h0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_stall_cnt <= '0;
        end else if (cpu_req && !cpu_gnt && (cpu_stall_cnt != {STALL_W{1'b1}})) begin
            cpu_stall_cnt <= cpu_stall_cnt + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table-driven cycles with a response
// scoreboard, plus hand-written sequences for saturation and mid-cycle reset.
module tb_dmem_arbiter;

    localparam int DEPTH   = 64;
    localparam int STALL_W = 4;

    logic               clk;
    logic               rst_n;
    logic               cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0]        cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic               cpu_gnt, cpu_rvalid, cpu_err, dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0]        cpu_rdata, dbg_rdata;
    logic [STALL_W-1:0] cpu_stall_cnt;
    logic               mem_we;
    logic [31:0]        mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.DEPTH_WORDS(DEPTH), .STALL_W(STALL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .cpu_stall_cnt(cpu_stall_cnt),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model ignores high address bits, so stray writes would alias onto real words.
    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        dr, dw;
        logic [31:0] da, dd;
        logic        eg_c, eg_d, e_we;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    vec_t  tbl [20];
    resp_t exp_q [$];
    resp_t mon_r;
    int    tests = 0;
    int    fails = 0;
    logic  mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:2] < 30'(DEPTH));
    endfunction

    task automatic push_exp(input logic port, input logic we, input logic [31:0] a,
                            input logic [31:0] d);
        resp_t r;
        r.port  = port;
        r.err   = !legal(a);
        r.rdata = (!we && legal(a)) ? ref_mem[a[7:2]] : 32'h0;
        if (we && legal(a)) ref_mem[a[7:2]] = d;
        exp_q.push_back(r);
    endtask

    task automatic step(input vec_t v);
        logic [31:0] exp_addr;
        @(negedge clk);
        cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
        dbg_req = v.dr; dbg_we = v.dw; dbg_addr = v.da; dbg_wdata = v.dd;
        #1;
        check("cpu_gnt", {31'b0, cpu_gnt}, {31'b0, v.eg_c});
        check("dbg_gnt", {31'b0, dbg_gnt}, {31'b0, v.eg_d});
        check("mem_we", {31'b0, mem_we}, {31'b0, v.e_we});
        exp_addr = v.eg_c ? v.ca : (v.eg_d ? v.da : 32'h0);
        check("mem_addr", mem_addr, exp_addr);
        if (v.eg_c)      push_exp(1'b0, v.cw, v.ca, v.cd);
        else if (v.eg_d) push_exp(1'b1, v.dw, v.da, v.dd);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        #1 mon_en = 1'b1;
    endtask

    // One response is due exactly one cycle after each grant, none otherwise.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                mon_r = exp_q.pop_front();
                if (mon_r.port == 1'b0) begin
                    check("cpu_rvalid", {31'b0, cpu_rvalid}, 32'h1);
                    check("dbg_rvalid_idle", {31'b0, dbg_rvalid}, 32'h0);
                    check("cpu_rdata", cpu_rdata, mon_r.rdata);
                    check("cpu_err", {31'b0, cpu_err}, {31'b0, mon_r.err});
                end else begin
                    check("dbg_rvalid", {31'b0, dbg_rvalid}, 32'h1);
                    check("cpu_rvalid_idle", {31'b0, cpu_rvalid}, 32'h0);
                    check("dbg_rdata", dbg_rdata, mon_r.rdata);
                    check("dbg_err", {31'b0, dbg_err}, {31'b0, mon_r.err});
                end
            end else begin
                check("no_rvalid", {30'b0, cpu_rvalid, dbg_rvalid}, 32'h0);
            end
        end
    end

    initial begin
        vec_t v;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end

        //             cr cw ca          cd            dr dw da          dd            gc gd we
        tbl[0]  = '{1, 1, 32'h10,  32'hDEADBEEF, 0, 0, 32'h0,   32'h0,        1, 0, 1};
        tbl[1]  = '{1, 0, 32'h10,  32'h0,        0, 0, 32'h0,   32'h0,        1, 0, 0};
        tbl[2]  = '{0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,        0, 0, 0};
        for (int i = 3; i < 9; i++)
            tbl[i] = '{1, 0, 32'h10, 32'h0, 1, 0, 32'h14, 32'h0, (i % 2) == 1, (i % 2) == 0, 0};
        tbl[9]  = '{0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,        0, 0, 0};
        tbl[10] = '{0, 0, 32'h0,   32'h0,        1, 1, 32'h20,  32'h12345678, 0, 1, 1};
        tbl[11] = '{1, 0, 32'h20,  32'h0,        0, 0, 32'h0,   32'h0,        1, 0, 0};
        tbl[12] = '{0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,        0, 0, 0};
        tbl[13] = '{1, 1, 32'h0,   32'hA5A5A5A5, 0, 0, 32'h0,   32'h0,        1, 0, 1};
        tbl[14] = '{1, 1, 32'h102, 32'h11111111, 0, 0, 32'h0,   32'h0,        1, 0, 0};
        tbl[15] = '{1, 1, 32'h100, 32'h22222222, 0, 0, 32'h0,   32'h0,        1, 0, 0};
        tbl[16] = '{1, 0, 32'h12,  32'h0,        0, 0, 32'h0,   32'h0,        1, 0, 0};
        tbl[17] = '{1, 0, 32'h100, 32'h0,        0, 0, 32'h0,   32'h0,        1, 0, 0};
        tbl[18] = '{1, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,        1, 0, 0};
        tbl[19] = '{0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,        0, 0, 0};

        do_reset();
        check("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
        check("rst_dbg_rvalid", {31'b0, dbg_rvalid}, 32'h0);
        check("rst_err", {30'b0, cpu_err, dbg_err}, 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_dbg_rdata", dbg_rdata, 32'h0);
        check("rst_stall", 32'(cpu_stall_cnt), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);

        for (int i = 0; i < 3; i++) step(tbl[i]);
        do_reset();
        for (int i = 3; i < 10; i++) step(tbl[i]);
        check("stall_after_contention", 32'(cpu_stall_cnt), 32'd3);
        for (int i = 10; i < 20; i++) step(tbl[i]);
        step(tbl[19]);
        check("stall_held", 32'(cpu_stall_cnt), 32'd3);
        check("mem_word0_intact", mem[0], 32'hA5A5A5A5);

        // Permanent contention: the CPU waits every other cycle until the counter pins.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            v = '{1, 0, 32'h4, 32'h0, 1, 0, 32'h8, 32'h0, (i % 2) == 0, (i % 2) == 1, 0};
            step(v);
            if (i == 10) check("stall_mid", 32'(cpu_stall_cnt), 32'd5);
        end
        step(tbl[19]);
        step(tbl[19]);
        check("stall_saturated", 32'(cpu_stall_cnt), 32'd15);

        // Asynchronous reset in the middle of a granted read.
        do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        #1 check("mid_gnt", {31'b0, cpu_gnt}, 32'h1);
        @(posedge clk);
        #1 check("mid_rvalid_pre", {31'b0, cpu_rvalid}, 32'h1);
        check("mid_rdata_pre", cpu_rdata, ref_mem[4]);
        #2 rst_n = 1'b0;
        cpu_we = 1;
        #1 check("mid_rvalid_drop", {31'b0, cpu_rvalid}, 32'h0);
        check("rst_gnt_follows", {31'b0, cpu_gnt}, 32'h1);
        check("rst_mem_we_forced", {31'b0, mem_we}, 32'h0);
        @(posedge clk);
        #1 check("rst_held_rvalid", {31'b0, cpu_rvalid}, 32'h0);
        @(negedge clk);
        cpu_req = 0; cpu_we = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_rst_rvalid", {30'b0, cpu_rvalid, dbg_rvalid}, 32'h0);
        @(negedge clk);
        cpu_req = 1; dbg_req = 1; dbg_addr = 32'h8;
        #1 check("post_rst_tie_cpu", {30'b0, cpu_gnt, dbg_gnt}, 32'h2);
        cpu_req = 0; dbg_req = 0;
        @(posedge clk);
        #1 check("post_rst_quiet", {30'b0, cpu_rvalid, dbg_rvalid}, 32'h0);
        check("rst_write_blocked", mem[4], ref_mem[4]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
